// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per cycle, fixed latency.
// Optional macro DIV_SIGNED_EN builds the two's-complement (DIV) path; otherwise all divides are unsigned.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dmag_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   rem_sh_d;
  logic [WIDTH:0]   trial_d;

  // rem_sh < 2*divisor, so the signed difference always fits in WIDTH+1 bits.
  assign rem_sh_d = {rem_q, quo_q[WIDTH-1]};
  assign trial_d  = rem_sh_d - {1'b0, dmag_q};

`ifdef DIV_SIGNED_EN
  logic             qneg_q;
  logic             rneg_q;
  logic             zero_q;
  logic [WIDTH-1:0] dvd_q;

  // Plain WIDTH-bit negation: the most negative value maps onto itself and is read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
`else
  logic unused_sign;
  assign unused_sign = is_signed;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= S_BUSY;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_SIGNED_EN
            dmag_q      <= mag(divisor, is_signed);
            quo_q       <= mag(dividend, is_signed);
            qneg_q      <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q      <= is_signed && dividend[WIDTH-1];
            zero_q      <= (divisor == '0);
            dvd_q       <= dividend;
`else
            dmag_q      <= divisor;
            quo_q       <= dividend;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (cnt_q == CW'(WIDTH)) begin
            // Extra cycle after the last iteration applies the result fix-up.
            state_q <= S_DONE;
            done_q  <= 1'b1;
`ifdef DIV_SIGNED_EN
            if (zero_q) begin
              quotient_q  <= '1;
              remainder_q <= dvd_q;
            end else begin
              quotient_q  <= neg_if(quo_q, qneg_q);
              remainder_q <= neg_if(rem_q, rneg_q);
            end
`else
            quotient_q  <= quo_q;
            remainder_q <= rem_q;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) busy_q <= 1'b0;
            if (!trial_d[WIDTH]) begin
              rem_q <= trial_d[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= rem_sh_d[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
